// File: rtl/object_line_scanner_if.sv
// rtl/object_line_scanner_if.sv - object snapshot, scan control and pixel result bundle
interface object_line_scanner_if #(
   parameter int NUM_OBJ  = 10,
   parameter int OBJ_SIZE = 32
);
   localparam int UW = $clog2(OBJ_SIZE);

   logic                   frame_start;
   logic                   line_start;
   logic [9:0]             next_line;
   logic [9:0]             draw_x;
   logic                   draw_en;
   logic [10*NUM_OBJ-1:0]  x_flat;
   logic [10*NUM_OBJ-1:0]  y_flat;
   logic [3*NUM_OBJ-1:0]   state_flat;
   logic [2:0]             type0;
   logic                   busy;
   logic                   obj_hit;
   logic [3:0]             obj_id;
   logic [UW-1:0]          obj_u;
   logic [UW-1:0]          obj_v;
   logic [2:0]             obj_type;
   logic                   line_overflow;

   modport master (
      output frame_start, line_start, next_line, draw_x, draw_en,
             x_flat, y_flat, state_flat, type0,
      input  busy, obj_hit, obj_id, obj_u, obj_v, obj_type, line_overflow
   );

   modport slave (
      input  frame_start, line_start, next_line, draw_x, draw_en,
             x_flat, y_flat, state_flat, type0,
      output busy, obj_hit, obj_id, obj_u, obj_v, obj_type, line_overflow
   );
endinterface

// File: rtl/object_line_scanner.sv
// rtl/object_line_scanner.sv - per-scanline sprite list builder and pixel hit resolver
module object_line_scanner #(
   parameter int NUM_OBJ      = 10,
   parameter int OBJ_SIZE     = 32,
   parameter int MAX_PER_LINE = 4
) (
   input logic                  clk,
   input logic                  reset,
   object_line_scanner_if.slave bus
);
   localparam int UW = $clog2(OBJ_SIZE);
   localparam int IW = $clog2(NUM_OBJ);
   localparam int CW = $clog2(MAX_PER_LINE + 1);
   localparam logic [9:0]    SIZE = 10'(OBJ_SIZE);
   localparam logic [CW-1:0] MAXC = CW'(MAX_PER_LINE);
   localparam logic [IW-1:0] LAST = IW'(NUM_OBJ - 1);

   typedef enum logic {IDLE, SCAN} state_t;
   state_t state_q, state_d;

   logic [9:0]    sh_x  [NUM_OBJ];
   logic [9:0]    sh_y  [NUM_OBJ];
   logic [2:0]    sh_st [NUM_OBJ];
   logic [2:0]    sh_type0;
   logic          pending_q;

   logic [IW-1:0] idx_q;
   logic [9:0]    line_q;
   logic [3:0]    slot_id [MAX_PER_LINE];
   logic [9:0]    slot_x  [MAX_PER_LINE];
   logic [UW-1:0] slot_v  [MAX_PER_LINE];
   logic [CW-1:0] count_q;
   logic          overflow_q;

   logic          scan_last, load, match;
   logic [9:0]    dy, dx;
   logic          pix_hit;
   logic [3:0]    pix_id;
   logic [UW-1:0] pix_u, pix_v;

   assign scan_last = (state_q == SCAN) && (idx_q == LAST);
   // A reload is deferred while scanning so the list is built from one consistent snapshot.
   assign load = (bus.frame_start || pending_q) &&
                 ((state_q == IDLE) || (scan_last && !bus.line_start));

   assign dy    = line_q - sh_y[idx_q];
   assign match = (sh_st[idx_q] != 3'd0) && (line_q >= sh_y[idx_q]) && (dy < SIZE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.line_start) state_d = SCAN;
         SCAN:    if (!bus.line_start && scan_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < NUM_OBJ; k++) begin
            sh_x[k]  <= '0;
            sh_y[k]  <= '0;
            sh_st[k] <= '0;
         end
         sh_type0  <= '0;
         pending_q <= 1'b0;
      end else if (load) begin
         for (int k = 0; k < NUM_OBJ; k++) begin
            sh_x[k]  <= bus.x_flat[10*k +: 10];
            sh_y[k]  <= bus.y_flat[10*k +: 10];
            sh_st[k] <= bus.state_flat[3*k +: 3];
         end
         sh_type0  <= bus.type0;
         pending_q <= 1'b0;
      end else if (bus.frame_start) begin
         pending_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx_q      <= '0;
         line_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         for (int s = 0; s < MAX_PER_LINE; s++) begin
            slot_id[s] <= '0;
            slot_x[s]  <= '0;
            slot_v[s]  <= '0;
         end
      end else if (bus.line_start) begin
         idx_q      <= '0;
         line_q     <= bus.next_line;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else if (state_q == SCAN) begin
         if (!scan_last) idx_q <= idx_q + 1'b1;
         if (match) begin
            if (count_q < MAXC) begin
               slot_id[count_q] <= 4'(idx_q);
               slot_x[count_q]  <= sh_x[idx_q];
               slot_v[count_q]  <= dy[UW-1:0];
               count_q          <= count_q + 1'b1;
            end else begin
               overflow_q <= 1'b1;
            end
         end
      end
   end

   // Walk slots from high to low so the lowest matching slot (lowest id) wins.
   always_comb begin
      pix_hit = 1'b0;
      pix_id  = '0;
      pix_u   = '0;
      pix_v   = '0;
      dx      = '0;
      if (bus.draw_en && (state_q == IDLE)) begin
         for (int s = MAX_PER_LINE - 1; s >= 0; s--) begin
            if ((CW'(s) < count_q) && (bus.draw_x >= slot_x[s]) &&
                ((bus.draw_x - slot_x[s]) < SIZE)) begin
               dx      = bus.draw_x - slot_x[s];
               pix_hit = 1'b1;
               pix_id  = slot_id[s];
               pix_u   = dx[UW-1:0];
               pix_v   = slot_v[s];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.obj_hit  <= 1'b0;
         bus.obj_id   <= '0;
         bus.obj_u    <= '0;
         bus.obj_v    <= '0;
         bus.obj_type <= '0;
      end else begin
         bus.obj_hit  <= pix_hit;
         bus.obj_id   <= pix_id;
         bus.obj_u    <= pix_u;
         bus.obj_v    <= pix_v;
         bus.obj_type <= (pix_hit && (pix_id == 4'd0)) ? sh_type0 : 3'd0;
      end
   end

   assign bus.busy          = (state_q == SCAN);
   assign bus.line_overflow = overflow_q;
endmodule

// File: tb/tb_object_line_scanner.sv
// tb/tb_object_line_scanner.sv - directed and randomized checks against a list-based reference model
module tb_object_line_scanner;
   localparam int N    = 10;
   localparam int SZ   = 32;
   localparam int MAXL = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   object_line_scanner_if #(.NUM_OBJ(N), .OBJ_SIZE(SZ)) bus();
   object_line_scanner #(.NUM_OBJ(N), .OBJ_SIZE(SZ), .MAX_PER_LINE(MAXL)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;
   int sx[N], sy[N], sst[N];
   int st0;
   int lid[$], lx[$], lv[$];
   logic exp_ovf;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic put_obj(input int i, input int x, input int y, input int st);
      bus.x_flat[10*i +: 10]    = 10'(x);
      bus.y_flat[10*i +: 10]    = 10'(y);
      bus.state_flat[3*i +: 3]  = 3'(st);
   endtask

   task automatic clear_objs;
      for (int i = 0; i < N; i++) put_obj(i, 0, 0, 0);
   endtask

   task automatic load_model;
      for (int i = 0; i < N; i++) begin
         sx[i]  = int'(bus.x_flat[10*i +: 10]);
         sy[i]  = int'(bus.y_flat[10*i +: 10]);
         sst[i] = int'(bus.state_flat[3*i +: 3]);
      end
      st0 = int'(bus.type0);
   endtask

   task automatic build_list(input int line);
      lid.delete(); lx.delete(); lv.delete();
      exp_ovf = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (sst[i] != 0 && line >= sy[i] && line - sy[i] < SZ) begin
            if (lid.size() < MAXL) begin
               lid.push_back(i); lx.push_back(sx[i]); lv.push_back(line - sy[i]);
            end else begin
               exp_ovf = 1'b1;
            end
         end
      end
   endtask

   function automatic logic [17:0] exp_pix(input int px);
      for (int s = 0; s < lid.size(); s++) begin
         if (px >= lx[s] && px - lx[s] < SZ)
            return {1'b1, 4'(lid[s]), 5'(px - lx[s]), 5'(lv[s]),
                    (lid[s] == 0) ? 3'(st0) : 3'd0};
      end
      return 18'd0;
   endfunction

   function automatic logic [31:0] pix_obs;
      return 32'({bus.obj_hit, bus.obj_id, bus.obj_u, bus.obj_v, bus.obj_type});
   endfunction

   task automatic frame;
      bus.frame_start = 1'b1;
      step;
      bus.frame_start = 1'b0;
      load_model();
   endtask

   // fs_at: -1 none, -2 frame_start with line_start, k>=0 frame_start on busy cycle k.
   // rs_at: busy cycle at which line_start restarts with line2, -1 for none.
   task automatic scan(input string tag, input int line, input int fs_at,
                       input int rs_at, input int line2);
      int cur_line, n;
      logic pend, exp_busy;
      bus.line_start = 1'b1;
      bus.next_line  = 10'(line);
      if (fs_at == -2) bus.frame_start = 1'b1;
      step;
      bus.line_start  = 1'b0;
      bus.frame_start = 1'b0;
      if (fs_at == -2) load_model();
      cur_line = line;
      pend = 1'b0;
      n = 0;
      for (int c = 0; c < 3*N; c++) begin
         exp_busy = (n < N);
         check({tag, "_busy"}, 32'(bus.busy), 32'(exp_busy));
         if (!exp_busy) break;
         if (c == fs_at) bus.frame_start = 1'b1;
         if (c == rs_at) begin
            bus.line_start = 1'b1;
            bus.next_line  = 10'(line2);
         end
         step;
         bus.frame_start = 1'b0;
         bus.line_start  = 1'b0;
         if (c == rs_at) begin
            cur_line = line2;
            n = 0;
         end else begin
            n++;
         end
         if (c == fs_at) pend = 1'b1;
      end
      build_list(cur_line);
      if (pend) load_model();
      check({tag, "_ovf"}, 32'(bus.line_overflow), 32'(exp_ovf));
   endtask

   task automatic sweep(input string tag);
      bus.draw_en = 1'b1;
      for (int x = 0; x < 640; x++) begin
         bus.draw_x = 10'(x);
         step;
         check({tag, "_pix"}, pix_obs(), 32'(exp_pix(x)));
      end
      bus.draw_en = 1'b0;
      step;
      check({tag, "_blank"}, pix_obs(), 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      bus.frame_start = 1'b0;
      bus.line_start  = 1'b0;
      bus.next_line   = '0;
      bus.draw_x      = '0;
      bus.draw_en     = 1'b0;
      bus.type0       = '0;
      clear_objs();
      load_model();
      lid.delete(); lx.delete(); lv.delete();
      step; step;
      check("reset_pix",  pix_obs(), 32'd0);
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_ovf",  32'(bus.line_overflow), 32'd0);
      reset = 1'b1;
      step;

      // all inactive: random coordinates, state 0
      for (int i = 0; i < N; i++) put_obj(i, $urandom_range(0, 600), $urandom_range(80, 110), 0);
      frame();
      scan("inactive", 100, -1, -1, 0);
      sweep("inactive");

      // single object 3
      clear_objs();
      put_obj(3, 200, 50, 1);
      bus.type0 = 3'd6;
      frame();
      scan("obj3_l60", 60, -1, -1, 0);
      sweep("obj3_l60");
      scan("obj3_l82", 82, -1, -1, 0);
      sweep("obj3_l82");

      // six objects on one row: overflow after four
      clear_objs();
      for (int i = 0; i < 6; i++) put_obj(i, 40*i, 10, 1);
      bus.type0 = 3'd5;
      frame();
      scan("ovf", 10, -1, -1, 0);
      sweep("ovf");

      // overlap of objects 0 and 1: lower id wins and carries type0
      put_obj(0, 100, 10, 2);
      put_obj(1, 100, 10, 1);
      frame();
      scan("overlap", 10, -1, -1, 0);
      sweep("overlap");

      // inputs change without frame_start: snapshot unchanged
      put_obj(0, 300, 0, 1);
      put_obj(2, 500, 0, 1);
      scan("noload", 10, -1, -1, 0);
      sweep("noload");

      // frame_start while busy: applied only when the scan ends
      clear_objs();
      put_obj(7, 100, 200, 1);
      put_obj(8, 300, 210, 1);
      frame();
      put_obj(7, 400, 205, 1);
      put_obj(8, 0, 300, 1);
      put_obj(9, 50, 215, 3);
      scan("pend_old", 220, 3, -1, 0);
      sweep("pend_old");
      scan("pend_new", 220, -1, -1, 0);
      sweep("pend_new");

      // restart during scan with a different line
      scan("restart", 300, -1, 4, 215);
      sweep("restart");

      // frame_start and line_start together: scan sees new snapshot
      for (int i = 0; i < N; i++) put_obj(i, $urandom_range(0, 640), $urandom_range(380, 420), $urandom_range(0, 3));
      bus.type0 = 3'($urandom_range(0, 7));
      scan("same_edge", 410, -2, -1, 0);
      sweep("same_edge");

      // randomized rounds
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < N; i++)
            put_obj(i, $urandom_range(0, 700), 100 + $urandom_range(0, 60), $urandom_range(0, 3));
         bus.type0 = 3'($urandom_range(0, 7));
         frame();
         scan("rand", 120 + $urandom_range(0, 40), -1, -1, 0);
         sweep("rand");
      end

      // reset in the middle of a scan
      clear_objs();
      put_obj(0, 10, 20, 1);
      frame();
      scan("pre_rst", 30, -1, -1, 0);
      bus.draw_en = 1'b1;
      bus.draw_x  = 10'd15;
      step;
      check("pre_rst_hit", 32'(bus.obj_hit), 32'd1);
      bus.draw_en = 1'b0;
      bus.line_start = 1'b1;
      bus.next_line  = 10'd30;
      step;
      bus.line_start = 1'b0;
      step; step; step;
      reset = 1'b0;
      #1;
      check("rst_mid_busy", 32'(bus.busy), 32'd0);
      check("rst_mid_pix",  pix_obs(), 32'd0);
      check("rst_mid_ovf",  32'(bus.line_overflow), 32'd0);
      for (int i = 0; i < N; i++) begin sx[i] = 0; sy[i] = 0; sst[i] = 0; end
      st0 = 0;
      lid.delete(); lx.delete(); lv.delete();
      step;
      reset = 1'b1;
      step;
      check("post_rst_busy", 32'(bus.busy), 32'd0);
      sweep("post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
